// File: rtl/fnd_pkg.sv
// fnd_pkg: FND message codes and the 2-bit scheduler state encoding.
package fnd_pkg;
  localparam logic [31:0] FND_BLANK = 32'h00CC_0000;
  localparam logic [31:0] FND_ERROR = 32'h00EE_0000;
  localparam logic [31:0] FND_PLUS  = 32'h0010_0000;
  localparam logic [31:0] FND_MINUS = 32'h0020_0000;
  localparam logic [31:0] FND_MUL   = 32'h0030_0000;
  localparam logic [31:0] FND_DIV   = 32'h0040_0000;
  localparam logic [31:0] FND_MOD   = 32'h0050_0000;
  localparam logic [31:0] FND_HAPPY = 32'h00A0_0000;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHOW = 2'd1, ST_GAP = 2'd2} state_e;
endpackage

// File: rtl/fnd_prio_arb.sv
// fnd_prio_arb: combinational fixed-priority picker, lowest index wins.
//   req_i   : request vector
//   valid_o : any request present
//   idx_o   : index of the winning request (0 when none)
module fnd_prio_arb
  import fnd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  output logic            valid_o,
  output logic [IW-1:0]   idx_o
);
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (req_i[i]) idx_o = IW'(i);
  end
endmodule

// File: rtl/fnd_msg_scheduler.sv
// fnd_msg_scheduler: shares the FND word between prioritised message requesters and a live base value.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   tick_i          : time-base strobe for dwell and gap counting
//   base_data_i     : live value shown while idle
//   blank_i         : forces the blank code on the output
//   req_i/req_data_i: level requests and per-channel message words
//   ack_o           : one-cycle grant pulse
//   fnd_serial_o    : registered display word
//   busy_o, src_o   : showing/gapping flag and channel being shown
module fnd_msg_scheduler
  import fnd_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWELL     = 1000,
  parameter int GAP_TICKS = 50,
  parameter int CW        = 16,
  localparam int SW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tick_i,
  input  logic [31:0]          base_data_i,
  input  logic                 blank_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*32-1:0]   req_data_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [31:0]          fnd_serial_o,
  output logic                 busy_o,
  output logic [SW-1:0]        src_o
);
  state_e state_q, state_d;
  logic [CW-1:0] dwell_q, dwell_d, gap_q, gap_d;
  logic [31:0] msg_q, msg_d, fnd_q, fnd_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [SW-1:0] src_q, src_d, gidx;
  logic busy_q, busy_d, arb_valid, grant;
  fnd_prio_arb #(.NREQ(NREQ), .IW(SW)) u_arb (
    .req_i  (req_i),
    .valid_o(arb_valid),
    .idx_o  (gidx)
  );
  // A preemption always lands on channel 0, which the arbiter picks whenever req_i[0] is high.
  assign grant = (state_q == ST_IDLE) ? arb_valid : (src_q != '0) && req_i[0];
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    gap_d = gap_q;
    msg_d = msg_q;
    src_d = src_q;
    ack_d = grant ? NREQ'(1) << gidx : '0;
    if (grant) begin
      state_d = ST_SHOW;
      dwell_d = CW'(DWELL);
      msg_d = req_data_i[gidx*32 +: 32];
      src_d = gidx;
    end else if (tick_i && state_q == ST_SHOW) begin
      dwell_d = dwell_q - CW'(1);
      if (dwell_q == CW'(1)) begin
        state_d = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
        gap_d = CW'(GAP_TICKS);
        src_d = (GAP_TICKS == 0) ? '0 : src_q;
      end
    end else if (tick_i && state_q == ST_GAP) begin
      gap_d = gap_q - CW'(1);
      if (gap_q == CW'(1)) begin
        state_d = ST_IDLE;
        src_d = '0;
      end
    end
    busy_d = state_d != ST_IDLE;
    fnd_d = blank_i ? FND_BLANK : state_d == ST_IDLE ? base_data_i : state_d == ST_SHOW ? msg_d : FND_BLANK;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      gap_q <= '0;
      msg_q <= '0;
      fnd_q <= FND_BLANK;
      ack_q <= '0;
      src_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      gap_q <= gap_d;
      msg_q <= msg_d;
      fnd_q <= fnd_d;
      ack_q <= ack_d;
      src_q <= src_d;
      busy_q <= busy_d;
    end
  end
  assign ack_o = ack_q;
  assign fnd_serial_o = fnd_q;
  assign busy_o = busy_q;
  assign src_o = src_q;
endmodule

// File: tb/tb_fnd_msg_scheduler.sv
// tb_fnd_msg_scheduler: two scheduler instances (3/1 and 1/0 dwell/gap) checked against a tick-timeline model.
module tb_fnd_msg_scheduler;
  import fnd_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, tick = 1'b0, blank = 1'b0;
  logic [31:0] base = 32'h0000_1234;
  logic [3:0] req_a = '0, req_b = '0, ack_a, ack_b;
  logic [127:0] rdata = '0;
  logic [31:0] fnd_a, fnd_b;
  logic busy_a, busy_b;
  logic [1:0] src_a, src_b;
  int n_chk = 0, n_fail = 0, cyc = 0, tc = 0;
  int dw[2] = '{3, 1};
  int gp[2] = '{1, 0};
  bit act[2];
  int gtc[2], ch[2];
  logic [31:0] msg[2];
  logic [3:0] eack[2];
  always #5 clk = ~clk;
  fnd_msg_scheduler #(.NREQ(4), .DWELL(3), .GAP_TICKS(1), .CW(16)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .base_data_i(base), .blank_i(blank),
    .req_i(req_a), .req_data_i(rdata), .ack_o(ack_a), .fnd_serial_o(fnd_a), .busy_o(busy_a), .src_o(src_a));
  fnd_msg_scheduler #(.NREQ(4), .DWELL(1), .GAP_TICKS(0), .CW(16)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .base_data_i(base), .blank_i(blank),
    .req_i(req_b), .req_data_i(rdata), .ack_o(ack_b), .fnd_serial_o(fnd_b), .busy_o(busy_b), .src_o(src_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  // 0 idle, 1 showing, 2 gap: derived from ticks elapsed since the grant
  function automatic int phase(input int k);
    int el;
    if (!act[k]) return 0;
    el = tc - gtc[k];
    return (el < dw[k]) ? 1 : (el < dw[k] + gp[k]) ? 2 : 0;
  endfunction
  task automatic model(input int k, input logic [3:0] rq);
    int ph, g;
    ph = phase(k);
    g = -1;
    if (ph == 0) begin
      for (int i = 3; i >= 0; i--) if (rq[i]) g = i;
    end else if (ch[k] != 0 && rq[0]) g = 0;
    eack[k] = '0;
    if (g >= 0) begin
      act[k] = 1'b1;
      gtc[k] = tc + int'(tick);
      ch[k] = g;
      msg[k] = rdata[g*32 +: 32];
      eack[k][g] = 1'b1;
    end
  endtask
  task automatic step();
    logic [31:0] eb;
    logic bl;
    tick = (cyc % 4 == 3);
    eb = base;
    bl = blank;
    if (rst_n) begin
      model(0, req_a);
      model(1, req_b);
      tc += int'(tick);
    end else begin
      act = '{0, 0};
      eack = '{4'd0, 4'd0};
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      int ph;
      ph = phase(k);
      chk($sformatf("fnd%0d", k), k ? fnd_b : fnd_a,
          (!rst_n || bl || ph == 2) ? FND_BLANK : (ph == 0) ? eb : msg[k]);
      chk($sformatf("busy%0d", k), 32'(k ? busy_b : busy_a), 32'(ph != 0));
      chk($sformatf("ack%0d", k), 32'(k ? ack_b : ack_a), 32'(eack[k]));
      chk($sformatf("src%0d", k), 32'(k ? src_b : src_a), (ph != 0) ? 32'(ch[k]) : 32'd0);
    end
    req_a &= ~ack_a;
    req_b &= ~ack_b;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_fnd", fnd_a, FND_BLANK);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_src", 32'(src_a), 32'd0);
    req_a = '0;
    req_b = '0;
    step();
    rst_n = 1'b1;
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 80 && (busy_a || busy_b); n++) step();
    chk("idle_a", 32'(busy_a), 32'd0);
    chk("idle_b", 32'(busy_b), 32'd0);
  endtask
  initial begin
    int n, t, dcyc, c3, bc_a, bc_b;
    bit saw;
    int order[$];
    #2 rst_n = 1'b0;
    #1;
    chk("init_fnd", fnd_a, FND_BLANK);
    step();
    rst_n = 1'b1;
    step();
    chk("base_after_rst", fnd_a, 32'h0000_1234);
    // single message on channel 2
    rdata[2*32 +: 32] = FND_PLUS;
    req_a[2] = 1'b1;
    req_b[2] = 1'b1;
    step();
    chk("single_ack", 32'(ack_a), 32'h4);
    chk("single_src", 32'(src_a), 32'd2);
    chk("single_fnd", fnd_a, FND_PLUS);
    wait_idle();
    step();
    // reset asserted mid-SHOW
    rdata[3*32 +: 32] = FND_HAPPY;
    req_a[3] = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    do_reset();
    step();
    chk("post_rst_base", fnd_a, 32'h0000_1234);
    // simultaneous requests on channels 1 and 3
    rdata[1*32 +: 32] = FND_MINUS;
    rdata[3*32 +: 32] = FND_MUL;
    req_a = 4'b1010;
    req_b = 4'b1010;
    dcyc = -1;
    c3 = -1;
    for (n = 0; n < 100 && order.size() < 2; n++) begin
      step();
      if (ack_a != 0) order.push_back((ack_a == 4'b0010) ? 1 : (ack_a == 4'b1000) ? 3 : 9);
      if (ack_a[3]) c3 = cyc;
      if (order.size() == 1 && !busy_a && dcyc < 0) dcyc = cyc;
    end
    chk("sim_count", 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      chk("sim_first", 32'(order[0]), 32'd1);
      chk("sim_second", 32'(order[1]), 32'd3);
    end
    chk("sim_idle_to_ack", 32'(c3 - dcyc), 32'd1);
    wait_idle();
    // preemption of channel 2 by channel 0 in the second dwell tick
    rdata[2*32 +: 32] = FND_DIV;
    req_a[2] = 1'b1;
    step();
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 8);
    rdata[0 +: 32] = FND_ERROR;
    req_a[0] = 1'b1;
    step();
    chk("pre_ack", 32'(ack_a), 32'h1);
    chk("pre_fnd", fnd_a, FND_ERROR);
    chk("pre_src", 32'(src_a), 32'd0);
    saw = 1'b0;
    for (n = 0; n < 60 && busy_a; n++) begin
      step();
      if (fnd_a == FND_DIV) saw = 1'b1;
    end
    chk("pre_no_reappear", 32'(saw), 32'd0);
    wait_idle();
    // blank during SHOW with a tick in the grant cycle
    while (cyc % 4 != 3) step();
    rdata[1*32 +: 32] = FND_MOD;
    req_a[1] = 1'b1;
    req_b[1] = 1'b1;
    blank = 1'b1;
    step();
    bc_a = 0;
    bc_b = 0;
    for (n = 0; n < 40 && (busy_a || busy_b); n++) begin
      bc_a += int'(busy_a);
      bc_b += int'(busy_b);
      step();
    end
    chk("blank_dwell_a", 32'(bc_a), 32'd16);
    chk("blank_dwell_b", 32'(bc_b), 32'd4);
    blank = 1'b0;
    step();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      base = $urandom;
      rdata = {$urandom, $urandom, $urandom, $urandom};
      blank = ($urandom_range(0, 9) == 0);
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 24) == 0) req_a[c] = 1'b1;
        if ($urandom_range(0, 24) == 0) req_b[c] = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end
    blank = 1'b0;
    req_a = '0;
    req_b = '0;
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fnd_msg_scheduler.md
# fnd_msg_scheduler

Sequencer that owns the `fnd_serial` word feeding the 6-digit FND segment driver. It shares the display between NREQ message requesters (operator names, error, HAPPY, results) and a live base value. Accepted messages are held for a fixed number of display ticks, followed by an optional blank gap. The result is that short-lived events stay readable before the display reverts to the live value.

## Interface
- NREQ, 4, number of requester channels; channel 0 is highest priority and may preempt.
- DWELL, 1000, ticks a granted message is displayed; legal range is at least 1.
- GAP_TICKS, 50, ticks of blank after a message; 0 skips the gap.
- CW, 16, width of the tick counters; DWELL and GAP_TICKS must each be below 2^CW.
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle strobe that sets the dwell/gap time base (e.g. 1 ms).
- base_data  in  32  live value shown while idle; passed through unmodified.
- blank  in  1  forces the blank code on the output; the FSM keeps running.
- req  in  NREQ  level request, one bit per channel.
- req_data  in  NREQ*32  message word per channel; channel i occupies bits [32i+31:32i].
- ack  out  NREQ  one-cycle grant pulse; at most one bit set at a time.
- fnd_serial  out  32  registered word sent to the segment driver.
- busy  out  1  high while the state is SHOW or GAP.
- src  out  clog2(NREQ)  channel currently shown; 0 when idle.

## Operation
- States:
  - IDLE: fnd_serial = base_data, refreshed every cycle.
  - SHOW: fnd_serial = latched message.
  - GAP: fnd_serial = 0x00CC_0000 (blank code).
- IDLE with any req high:
  - The lowest-index requesting channel is granted.
  - At that edge: req_data is latched, ack[i]=1, src=i, state moves to SHOW, and the dwell counter loads DWELL.
- SHOW:
  - Each tick decrements the dwell counter.
  - On a tick with counter==1: go to GAP with the gap counter loaded to GAP_TICKS, or go to IDLE if GAP_TICKS==0.
- GAP:
  - Each tick decrements the gap counter.
  - On a tick with counter==1: go to IDLE.
- Preemption:
  - In SHOW or GAP, if src!=0 and req[0] is high, channel 0 is granted at the next edge, exactly as from IDLE.
  - The preempted message is dropped and is not re-queued.
  - Channel 0 never preempts itself.
- Requests outside IDLE, other than the preemption case, are held pending; they are not acked and not lost while req stays high.
- req is level-sensitive. A requester must drop req in the cycle after its ack; if req is still high then, it counts as a new request.
- req_data is sampled only on the grant edge.
- blank=1 overrides the output with 0x00CC_0000 in every state. State, counters and ack behave as if blank were 0.
- Simultaneous events:
  - A tick in the grant cycle does not decrement the freshly loaded counter.
  - Grant in IDLE takes priority over base_data refresh.
  - Preemption takes priority over dwell expiry in the same cycle.

## Timing
- Reset values, all asynchronous on rst low: state=IDLE, fnd_serial=0x00CC_0000, ack=0, busy=0, src=0, both counters=0.
- The first edge after reset release loads base_data, or grants if a req is high.
- Grant latency: req sampled high at edge n produces ack, new fnd_serial, busy=1 and src valid after edge n.
- SHOW lasts from the grant edge until the edge of the DWELL-th tick strobe after grant.
- After returning to IDLE, at least one cycle passes before the next grant. Back-to-back messages are therefore separated by the gap plus one cycle.
- base_data to fnd_serial latency is 1 cycle in IDLE.
- Reset during SHOW or GAP aborts immediately. The pending message is lost, with no ack on release.

## Structure
- Shared package fnd_pkg holds:
  - message code constants: BLANK 0x00CC_0000, ERROR 0x00EE_0000, PLUS 0x0010_0000, MINUS 0x0020_0000, MUL 0x0030_0000, DIV 0x0040_0000, MOD 0x0050_0000, HAPPY 0x00A0_0000;
  - the 2-bit state encoding (IDLE=0, SHOW=1, GAP=2).
- Sub-module fnd_prio_arb: combinational fixed-priority picker taking req[NREQ-1:0] and producing a valid flag and a grant index.
- The FSM, counters and output register live in the top module.

## Test plan
Bench parameters: DWELL=3, GAP_TICKS=1, tick every 4 cycles.
- **Reset behaviour.** Assert rst low mid-SHOW. Required: fnd_serial=0x00CC_0000, busy=0, ack=0 asynchronously. After release, fnd_serial follows base_data=0x0000_1234.
- **Single message.** Pulse req[2] with data 0x0010_0000. Required: ack[2] for 1 cycle, src=2, PLUS shown for 3 ticks, then blank for 1 tick, then base_data.
- **Simultaneous requests.** Raise req[1] and req[3] together. Required: ch1 is acked first. ch3 stays pending and is acked 1 cycle after IDLE returns. No ack is lost.
- **Preemption.** Raise req[0]=0x00EE_0000 during ch2's second dwell tick. Required: ack[0] on the next edge, ERROR shown for a full 3 ticks, ch2's message never reappears.
- **Blank and tick coincidence.** Hold blank=1 during SHOW. Required: the output stays 0x00CC_0000 while the dwell still expires on schedule. A tick in the grant cycle does not shorten the dwell.
- **DWELL=1, GAP_TICKS=0 corner.** Required: the message is shown until the first tick, then the design goes directly to IDLE. busy drops on the same edge.
